// File: rtl/gate_stim_driver.sv
`default_nettype none
// ============================================================================
//  Module      : gate_stim_driver
//  Description : Stimulus driver and response compactor for 24-in / 10-out
//                combinational gate models. Steps a 24-bit LFSR through a run
//                of num_pat patterns, holds each for SETTLE cycles plus one
//                capture cycle, and folds the sampled response into a 10-bit
//                signature. start/done handshake, busy during a run.
//  Options     : GATE_STIM_MISR_EN - when defined, signature is a 10-bit MISR
//                (x^10+x^3+1); when undefined, signature is the raw response
//                captured for the last pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_stim_driver #(
    parameter int SETTLE = 2,   // cycles each pattern is held before capture, 1..255
    parameter int CNT_W  = 16   // pattern counter width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pat,
    input  logic [23:0]      seed,
    input  logic [9:0]       rsp,
    output logic [23:0]      pat,
    output logic             busy,
    output logic             done,
    output logic [9:0]       signature,
    output logic [CNT_W-1:0] pat_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Settle counter value on which the pattern slot moves to CAPTURE.
    localparam logic [7:0] C_SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q,  state_d;
    logic [7:0]       settle_q, settle_d;
    logic [23:0]      pat_q,    pat_d;
    logic [9:0]       sig_q,    sig_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] num_q,    num_d;

    logic [23:0]      w_lfsr_next;
    logic [9:0]       w_sig_capture;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [23:0]      w_seed_fix;

    // Next LFSR state: Fibonacci x^24+x^23+x^22+x^17+1, shifting towards the MSB.
    assign w_lfsr_next = {pat_q[22:0], pat_q[23] ^ pat_q[22] ^ pat_q[21] ^ pat_q[16]};

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    assign w_seed_fix  = (seed == 24'h000000) ? 24'h000001 : seed;

    assign w_cnt_inc   = cnt_q + C_CNT_ONE;

`ifdef GATE_STIM_MISR_EN
    // MISR x^10+x^3+1: rotate left, feed bit 9 back into bit 3, xor response.
    assign w_sig_capture = {sig_q[8:0], sig_q[9]} ^ {6'b0, sig_q[9], 3'b0} ^ rsp;
`else
    // Without compaction the signature is the raw response of the last capture.
    assign w_sig_capture = rsp;
`endif

    // State and datapath registers; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            settle_q <= 8'd0;
            pat_q    <= 24'd0;
            sig_q    <= 10'd0;
            cnt_q    <= '0;
            num_q    <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            pat_q    <= pat_d;
            sig_q    <= sig_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
        end
    end

    // Next-state, datapath updates and status outputs.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        pat_d    = pat_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        num_d    = num_q;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sig_d = 10'd0;
                    cnt_d = '0;
                    if (num_pat != '0) begin
                        num_d    = num_pat;
                        pat_d    = w_seed_fix;
                        settle_d = 8'd0;
                        state_d  = S_SETTLE;
                    end else begin
                        state_d  = S_DONE;
                    end
                end
            end

            S_SETTLE: begin
                busy = 1'b1;
                if (settle_q == C_SETTLE_LAST) begin
                    settle_d = 8'd0;
                    state_d  = S_CAPTURE;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end

            S_CAPTURE: begin
                busy  = 1'b1;
                sig_d = w_sig_capture;
                cnt_d = w_cnt_inc;
                if (w_cnt_inc == num_q) begin
                    state_d = S_DONE;
                end else begin
                    pat_d   = w_lfsr_next;
                    state_d = S_SETTLE;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pat       = pat_q;
    assign signature = sig_q;
    assign pat_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: doc/gate_stim_driver.md
# gate_stim_driver

Upstream stimulus stage and response compactor for the 24-input / 10-output combinational gate models in the simulator gate library. It drives the gate model's 24 inputs with a pseudo-random pattern sequence and waits a programmable settle time. It then samples the model's 10 outputs and folds them into a signature register. A start/done handshake lets the lab microcomputer run a batch of patterns and read back one signature per run.

## Interface
Parameters:
- SETTLE, 2: cycles each pattern is held before its response is sampled; legal range 1..255.
- CNT_W, 16: width of the pattern counter.

Ports:
- clk, input, 1: single clock. All state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begin a run. Sampled only in IDLE.
- num_pat, input, CNT_W: number of patterns in the run. Latched when start is accepted.
- seed, input, 24: initial LFSR value. Latched when start is accepted.
- rsp, input, 10: gate model outputs, in order {N424,N414,N418,N375,N423,N407,N420,N421,N411,N419}. rsp[0] is N419.
- pat, output, 24: drives gate model inputs. pat[0] is N1 and pat[23] is N24.
- busy, output, 1: high while a run is in progress (states SETTLE and CAPTURE).
- done, output, 1: single-cycle pulse at the end of a run.
- signature, output, 10: compacted response. Held stable from done until the next accepted start.
- pat_cnt, output, CNT_W: number of patterns captured so far in the current or last run.

## Operation
States: IDLE, SETTLE, CAPTURE, DONE.

- **Reset:** state goes to IDLE. pat, signature, pat_cnt, busy and done are all 0. The settle counter is 0.
- **IDLE, start=1 and num_pat≠0:**
  - Latch num_pat.
  - Load pat with seed. A seed of 24'h000000 is replaced by 24'h000001.
  - Clear signature, pat_cnt and the settle counter.
  - Go to SETTLE.
- **IDLE, start=1 and num_pat=0:**
  - Clear signature and pat_cnt.
  - Go to DONE. busy never rises.
- **IDLE, start=0:** stay in IDLE; all outputs hold.
- **SETTLE:** increment the settle counter. On the edge where it reaches SETTLE-1, reset it to 0 and go to CAPTURE. pat holds.
- **CAPTURE (one cycle):** on the edge
  - signature updates with rsp;
  - pat_cnt increments;
  - if the new pat_cnt equals num_pat, go to DONE;
  - otherwise advance pat by one LFSR step and go to SETTLE.
- **DONE (one cycle):** done=1, busy=0. Go to IDLE.

Datapath rules:
- **start while busy:** start is ignored in SETTLE, CAPTURE and DONE. Changes to num_pat or seed during a run have no effect.
- **LFSR:** 24-bit Fibonacci, polynomial x^24+x^23+x^22+x^17+1.
  - fb = pat[23]^pat[22]^pat[21]^pat[16]
  - pat ← {pat[22:0], fb}
- **MISR:** 10-bit, polynomial x^10+x^3+1.
  - s'[0] = s[9]^rsp[0]
  - s'[3] = s[2]^s[9]^rsp[3]
  - s'[i] = s[i-1]^rsp[i] for every other bit i
- **pat_cnt wrap:** pat_cnt cannot wrap, because a run ends when pat_cnt equals num_pat, which fits in CNT_W.
- **Reset mid-run:** rst_n low in any state forces the reset values immediately, without waiting for a clock edge. The partial signature is lost.

## Timing
- pat for the first pattern is valid after the edge that accepts start (edge E0).
- Each pattern occupies SETTLE+1 cycles: SETTLE cycles in SETTLE plus one in CAPTURE.
- rsp is sampled on the last edge of each pattern slot. The gate model therefore gets SETTLE+1 full cycles of combinational settling.
- done is high in the cycle after edge E0+num_pat·(SETTLE+1).
- signature and pat_cnt are final in that same cycle.
- For num_pat=0, done is high in the cycle after E0.
- busy is high from after E0 through the final CAPTURE edge.
- start may be re-accepted in the cycle after done.

## Configuration
- Macro: GATE_STIM_MISR_EN.
- **Defined:** signature is the MISR described above.
- **Undefined:**
  - No MISR logic is built.
  - On each CAPTURE edge, signature ← rsp, so after done it holds the raw response to the last pattern.
  - All other behaviour and timing are identical.

## Test plan
Every scenario uses SETTLE=2 and GATE_STIM_MISR_EN defined, unless stated otherwise.
- **Reset:** rst_n low with no clock → pat=0, signature=0, pat_cnt=0, busy=0, done=0.
- **Single pattern:** num_pat=1, seed=24'h000001, rsp=10'h000, start for one cycle → done pulses one cycle after the third edge following E0; pat=24'h000001, pat_cnt=1, signature=10'h000.
- **LFSR sequence:** seed=0, num_pat=3 → pat takes 24'h000001, 24'h000002, 24'h000004 in turn. Separately, seed=24'h800000, num_pat=2 → second pattern is 24'h000001.
- **MISR fold:** rsp held at 10'h001, num_pat=2 → signature 10'h001 after the first capture and 10'h003 at done.
- **Empty run and ignored start:** num_pat=0 → done in the cycle after E0, busy stays 0. In a 4-pattern run, pulsing start mid-run changes nothing: done comes 12 cycles after E0 and pat_cnt=4.
- **Reset mid-run and no-MISR build:**
  - rst_n low during the second pattern → all outputs 0 at once and state IDLE.
  - With the macro undefined, rsp=10'h2A5 on the final capture → signature=10'h2A5.
